// File: rtl/wish_pkg.sv
// Shared definitions for the wishbone word packer: endian modes,
// accumulator states and the lane placement helper.
package wish_pkg;
  localparam bit ENDIAN_BIG    = 1'b0;
  localparam bit ENDIAN_LITTLE = 1'b1;

  typedef enum logic {
    ACC_FILL = 1'b0,
    ACC_HOLD = 1'b1
  } acc_state_e;

  // Bit offset of the k-th word of an output word; width=1 yields the lane number.
  function automatic int lane_offset(input int k, input int num_pack, input int width,
                                     input bit little_endian);
    return (little_endian ? k : num_pack - 1 - k) * width;
  endfunction
endpackage

// File: rtl/wish_pack_flex_if.sv
// Source and destination wishbone-style links of the packer, bundled in one interface.
interface wish_pack_flex_if
  import wish_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter int TGC_WIDTH  = 2
);
  localparam int CNT_WIDTH = $clog2(NUM_PACK + 1);

  logic                           s_cyc;
  logic                           s_stb;
  logic [DATA_WIDTH-1:0]          s_dat;
  logic [TGC_WIDTH-1:0]           s_tgc;
  logic                           s_last;
  logic                           s_ack;
  logic                           s_stall;
  logic                           d_cyc;
  logic                           d_stb;
  logic                           d_ack;
  logic [DATA_WIDTH*NUM_PACK-1:0] d_dat;
  logic [NUM_PACK-1:0]            d_sel;
  logic [TGC_WIDTH-1:0]           d_tgc;
  logic [CNT_WIDTH-1:0]           d_cnt;

  modport master (
    output s_cyc, s_stb, s_dat, s_tgc, s_last, d_ack,
    input  s_ack, s_stall, d_cyc, d_stb, d_dat, d_sel, d_tgc, d_cnt
  );

  modport slave (
    input  s_cyc, s_stb, s_dat, s_tgc, s_last, d_ack,
    output s_ack, s_stall, d_cyc, d_stb, d_dat, d_sel, d_tgc, d_cnt
  );
endinterface

// File: rtl/wish_pack_flex_core.sv
// Two-stage packer: accumulator gathers source words, output register presents them.
// state    | meaning
// ACC_FILL | accumulator collecting words, source may be accepted
// ACC_HOLD | completed word parked in accumulator (acc_done), source stalled
module wish_pack_flex_core
  import wish_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1
) (
  input logic             clk,
  input logic             rst_n,
  wish_pack_flex_if.slave bus
);
  localparam int PW = DATA_WIDTH * NUM_PACK;
  localparam int CW = $clog2(NUM_PACK + 1);
  localparam int IW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam bit LE = (LITTLE_ENDIAN != 0) ? ENDIAN_LITTLE : ENDIAN_BIG;

  acc_state_e          state;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       acc_dat, nxt_dat, out_dat;
  logic [NUM_PACK-1:0] acc_sel, nxt_sel, out_sel;
  logic [TGC_WIDTH-1:0] acc_tgc, nxt_tgc, out_tgc;
  logic [CW-1:0]       acc_cnt, nxt_cnt, out_cnt;
  logic                out_valid, out_free, accept, complete, acc_done;

  assign acc_done = (state == ACC_HOLD);
  // Reset gates acceptance directly so the first cycle after release can accept.
  assign accept   = rst_n & bus.s_cyc & bus.s_stb & ~acc_done;
  assign complete = accept & (bus.s_last | (idx == IW'(NUM_PACK - 1)));
  assign out_free = ~out_valid | bus.d_ack;

  // Unfilled lanes stay zero in the accumulator, so merging is a plain OR.
  always_comb begin
    nxt_dat = acc_dat | (PW'(bus.s_dat) << lane_offset(int'(idx), NUM_PACK, DATA_WIDTH, LE));
    nxt_sel = acc_sel | (NUM_PACK'(1) << lane_offset(int'(idx), NUM_PACK, 1, LE));
    nxt_tgc = acc_tgc | bus.s_tgc;
    nxt_cnt = acc_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC_FILL;
      idx       <= '0;
      acc_dat   <= '0;
      acc_sel   <= '0;
      acc_tgc   <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_dat   <= '0;
      out_sel   <= '0;
      out_tgc   <= '0;
      out_cnt   <= '0;
    end else begin
      if (out_valid && bus.d_ack) out_valid <= 1'b0;
      case (state)
        ACC_HOLD: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_dat   <= acc_dat;
            out_sel   <= acc_sel;
            out_tgc   <= acc_tgc;
            out_cnt   <= acc_cnt;
            state     <= ACC_FILL;
            idx       <= '0;
            acc_dat   <= '0;
            acc_sel   <= '0;
            acc_tgc   <= '0;
            acc_cnt   <= '0;
          end
        end
        default: begin
          if (complete && out_free) begin
            out_valid <= 1'b1;
            out_dat   <= nxt_dat;
            out_sel   <= nxt_sel;
            out_tgc   <= nxt_tgc;
            out_cnt   <= nxt_cnt;
            idx       <= '0;
            acc_dat   <= '0;
            acc_sel   <= '0;
            acc_tgc   <= '0;
            acc_cnt   <= '0;
          end else if (accept) begin
            acc_dat <= nxt_dat;
            acc_sel <= nxt_sel;
            acc_tgc <= nxt_tgc;
            acc_cnt <= nxt_cnt;
            if (complete) state <= ACC_HOLD;
            else          idx   <= idx + IW'(1);
          end
        end
      endcase
    end
  end

  assign bus.s_ack   = accept;
  assign bus.s_stall = acc_done;
  assign bus.d_cyc   = out_valid;
  assign bus.d_stb   = out_valid;
  assign bus.d_dat   = out_dat;
  assign bus.d_sel   = out_sel;
  assign bus.d_tgc   = out_tgc;
  assign bus.d_cnt   = out_cnt;
endmodule

// File: rtl/wish_pack_flex.sv
// Top of the word packer: flat bus ports mapped onto the link interface feeding the core.
module wish_pack_flex
  import wish_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                s_cyc_i,
  input  logic                                s_stb_i,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic [TGC_WIDTH-1:0]                s_tgc_i,
  input  logic                                s_last_i,
  output logic                                s_ack_o,
  output logic                                s_stall_o,
  output logic                                d_cyc_o,
  output logic                                d_stb_o,
  input  logic                                d_ack_i,
  output logic [DATA_WIDTH*NUM_PACK-1:0]      d_dat_o,
  output logic [NUM_PACK-1:0]                 d_sel_o,
  output logic [TGC_WIDTH-1:0]                d_tgc_o,
  output logic [$clog2(NUM_PACK+1)-1:0]       d_cnt_o
);
  wish_pack_flex_if #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_PACK  (NUM_PACK),
    .TGC_WIDTH (TGC_WIDTH)
  ) bus ();

  assign bus.s_cyc  = s_cyc_i;
  assign bus.s_stb  = s_stb_i;
  assign bus.s_dat  = s_dat_i;
  assign bus.s_tgc  = s_tgc_i;
  assign bus.s_last = s_last_i;
  assign bus.d_ack  = d_ack_i;

  assign s_ack_o   = bus.s_ack;
  assign s_stall_o = bus.s_stall;
  assign d_cyc_o   = bus.d_cyc;
  assign d_stb_o   = bus.d_stb;
  assign d_dat_o   = bus.d_dat;
  assign d_sel_o   = bus.d_sel;
  assign d_tgc_o   = bus.d_tgc;
  assign d_cnt_o   = bus.d_cnt;

  wish_pack_flex_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_PACK     (NUM_PACK),
    .TGC_WIDTH    (TGC_WIDTH),
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_core (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .bus  (bus)
  );
endmodule

// File: tb/tb_wish_pack_flex.sv
// Directed bench: little-endian, big-endian and single-lane packers share one source stream.
module tb_wish_pack_flex;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wish_pack_flex_if #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2)) bus ();

  logic        be_ack, be_stall, be_cyc, be_stb;
  logic [31:0] be_dat;
  logic [3:0]  be_sel;
  logic [1:0]  be_tgc;
  logic [2:0]  be_cnt;
  logic        p1_ack, p1_stall, p1_cyc, p1_stb;
  logic [7:0]  p1_dat;
  logic [0:0]  p1_sel;
  logic [1:0]  p1_tgc;
  logic [0:0]  p1_cnt;

  wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) u_le (
    .clk_i(clk), .rst_ni(rst_n), .s_cyc_i(bus.s_cyc), .s_stb_i(bus.s_stb), .s_dat_i(bus.s_dat),
    .s_tgc_i(bus.s_tgc), .s_last_i(bus.s_last), .s_ack_o(bus.s_ack), .s_stall_o(bus.s_stall),
    .d_cyc_o(bus.d_cyc), .d_stb_o(bus.d_stb), .d_ack_i(bus.d_ack), .d_dat_o(bus.d_dat),
    .d_sel_o(bus.d_sel), .d_tgc_o(bus.d_tgc), .d_cnt_o(bus.d_cnt));

  wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) u_be (
    .clk_i(clk), .rst_ni(rst_n), .s_cyc_i(bus.s_cyc), .s_stb_i(bus.s_stb), .s_dat_i(bus.s_dat),
    .s_tgc_i(bus.s_tgc), .s_last_i(bus.s_last), .s_ack_o(be_ack), .s_stall_o(be_stall),
    .d_cyc_o(be_cyc), .d_stb_o(be_stb), .d_ack_i(bus.d_ack), .d_dat_o(be_dat),
    .d_sel_o(be_sel), .d_tgc_o(be_tgc), .d_cnt_o(be_cnt));

  wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(1), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) u_p1 (
    .clk_i(clk), .rst_ni(rst_n), .s_cyc_i(bus.s_cyc), .s_stb_i(bus.s_stb), .s_dat_i(bus.s_dat),
    .s_tgc_i(bus.s_tgc), .s_last_i(bus.s_last), .s_ack_o(p1_ack), .s_stall_o(p1_stall),
    .d_cyc_o(p1_cyc), .d_stb_o(p1_stb), .d_ack_i(bus.d_ack), .d_dat_o(p1_dat),
    .d_sel_o(p1_sel), .d_tgc_o(p1_tgc), .d_cnt_o(p1_cnt));

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [7:0]  dat;
    logic [1:0]  tgc;
    logic        last;
    logic        e_ack;
    logic        e_stb;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic [1:0]  e_tgc;
    logic [2:0]  e_cnt;
    logic [31:0] e_be_dat;
    logic [3:0]  e_be_sel;
  } vec_t;

  vec_t        vt [16];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] got_q [$];

  always @(posedge clk)
    if (rst_n && bus.d_stb && bus.d_ack) got_q.push_back(bus.d_dat);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic [7:0] dat,
                       input logic [1:0] tgc, input logic last);
    bus.s_cyc  = cyc;
    bus.s_stb  = stb;
    bus.s_dat  = dat;
    bus.s_tgc  = tgc;
    bus.s_last = last;
  endtask

  initial begin
    vec_t        r;
    logic        p_stb;
    logic [7:0]  p_dat;
    logic [5:0]  a_c, e_c;
    logic [76:0] a_d, e_d;
    logic [9:0]  a_p, e_p;
    logic [31:0] exp_bp [3];
    int          k;

    //        cyc   stb   dat    tgc    last  ack   stb   d_dat         sel   tgc    cnt   be_dat        be_sel
    vt[0]  = '{1'b1, 1'b1, 8'h11, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[1]  = '{1'b1, 1'b1, 8'h22, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[2]  = '{1'b1, 1'b1, 8'h33, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[3]  = '{1'b1, 1'b1, 8'h44, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[4]  = '{1'b1, 1'b1, 8'h55, 2'b00, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 2'b11, 3'd4, 32'h11223344, 4'hF};
    vt[5]  = '{1'b1, 1'b1, 8'h66, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[6]  = '{1'b0, 1'b1, 8'h99, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[7]  = '{1'b1, 1'b0, 8'h99, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[8]  = '{1'b1, 1'b1, 8'h77, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[9]  = '{1'b1, 1'b1, 8'h88, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h88776655, 4'hF, 2'b00, 3'd4, 32'h55667788, 4'hF};
    vt[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[12] = '{1'b1, 1'b1, 8'hAB, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[13] = '{1'b1, 1'b1, 8'hCD, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};
    vt[14] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000CDAB, 4'h3, 2'b10, 3'd2, 32'hABCD0000, 4'hC};
    vt[15] = '{1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 2'b00, 3'd0, 32'h0,        4'h0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    bus.d_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 128'({bus.s_ack, bus.s_stall, bus.d_cyc, bus.d_stb, bus.d_dat,
                               bus.d_sel, bus.d_tgc, bus.d_cnt}), 128'(0));
    rst_n     = 1'b1;
    bus.d_ack = 1'b1;

    // Table: each row drives one cycle and checks that cycle's outputs.
    p_stb = 1'b0;
    p_dat = 8'h00;
    for (int i = 0; i < 16; i++) begin
      r = vt[i];
      drive(r.cyc, r.stb, r.dat, r.tgc, r.last);
      #1;
      a_c = {bus.s_ack, bus.s_stall, bus.d_cyc, bus.d_stb, be_stb, p1_stb};
      e_c = {r.e_ack, 1'b0, r.e_stb, r.e_stb, r.e_stb, p_stb};
      a_d = '0;
      e_d = '0;
      a_p = '0;
      e_p = '0;
      if (r.e_stb) begin
        a_d = {bus.d_dat, bus.d_sel, bus.d_tgc, bus.d_cnt, be_dat, be_sel};
        e_d = {r.e_dat, r.e_sel, r.e_tgc, r.e_cnt, r.e_be_dat, r.e_be_sel};
      end
      if (p_stb) begin
        a_p = {p1_dat, p1_sel, p1_cnt};
        e_p = {p_dat, 1'b1, 1'b1};
      end
      check($sformatf("row%0d", i), {35'd0, a_c, a_d, a_p}, {35'd0, e_c, e_d, e_p});
      p_stb = r.e_ack;
      p_dat = r.dat;
      @(posedge clk);
      #1;
    end

    // Backpressure: destination silent for 10 cycles under a continuous source.
    got_q.delete();
    exp_bp[0] = 32'hA3A2A1A0;
    exp_bp[1] = 32'hA7A6A5A4;
    exp_bp[2] = 32'hABAAA9A8;
    k = 0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      drive(1'b1, 1'b1, 8'hA0 + 8'(k), 2'b00, 1'b0);
      bus.d_ack = (c < 10) ? 1'b0 : 1'b1;
      #1;
      if (bus.s_ack) k++;
      if (c == 9) begin
        check("bp_accepted", 128'(k), 128'(8));
        check("bp_stall", 128'({bus.s_stall, bus.s_ack, bus.d_stb}), 128'(3'b101));
      end
      @(posedge clk);
      #1;
    end
    check("bp_total", 128'(k), 128'(12));
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    bus.d_ack = 1'b1;
    for (int w = 0; w < 20 && got_q.size() < 3; w++) @(posedge clk);
    #1;
    check("bp_drain", 128'(got_q.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("bp_word%0d", i), 128'((i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx),
            128'(exp_bp[i]));

    // Reset in the middle of a word discards it; packing restarts at lane 0.
    drive(1'b1, 1'b1, 8'hC1, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hC2, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hC3, 2'b11, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_reset", 128'({bus.s_ack, bus.s_stall, bus.d_cyc, bus.d_stb, bus.d_dat,
                             bus.d_sel, bus.d_tgc, bus.d_cnt}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'hD1, 2'b00, 1'b0);
    #1;
    check("first_ack_after_reset", 128'(bus.s_ack), 128'(1));
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hD2, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hD3, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 8'hD4, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    #1;
    check("post_reset_word", 128'({bus.d_stb, bus.d_cyc, bus.d_dat, bus.d_sel, bus.d_tgc, bus.d_cnt}),
          128'({1'b1, 1'b1, 32'hD4D3D2D1, 4'hF, 2'b00, 3'd4}));
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
